cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter T_WIDTH, default 3, width of the T-state counter; NUM_T = 2**T_WIDTH T-states.
REQ-002 Parameter CNT_WIDTH, default 16, width of the retired-instruction counter.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-005 mem_ready  input  1  memory/port ready; 0 inserts a wait state.
REQ-006 clr_timer  input  1  end-of-instruction request from control unit; next T-state is T[0].
REQ-007 hlt  input  1  halt request from control unit.
REQ-008 resume  input  1  leave HALT; rising-edge detected.
REQ-009 step_mode  input  1  1 = single-instruction stepping.
REQ-010 step_req  input  1  advance one instruction in step mode; rising-edge detected.
REQ-011 T  output  NUM_T  one-hot T-state strobe; all-zero when not in RUN/WAIT.
REQ-012 t_count  output  T_WIDTH  current T-state index.
REQ-013 instr_start  output  1  high for exactly the cycles where T[0]=1 and state=RUN.
REQ-014 waiting, halted, stepping  output  1 each  state indicators for WAIT, HALT, STEP_IDLE.
REQ-015 instr_count  output  CNT_WIDTH  retired-instruction count.
REQ-016 overrun  output  1  sticky flag: counter wrapped without clr_timer.

Function
REQ-017 States: IDLE, RUN, WAIT, HALT, STEP_IDLE; encoding is free, exactly one state active.
REQ-018 IDLE -> RUN on the first rising clk with reset=1; t_count=0 after that edge, so T[0] is the first strobe.
REQ-019 T = one-hot decode of t_count only in RUN or WAIT; otherwise T=0.
REQ-020 RUN edge priority: hlt > mem_ready=0 > clr_timer > t_count increment.
REQ-021 hlt=1 in RUN or WAIT -> HALT; t_count=0; instr_count +1 (HLT retires).
REQ-022 mem_ready=0 in RUN -> WAIT; t_count, T, instr_count held; waiting=1.
REQ-023 WAIT -> RUN on the first edge with mem_ready=1; t_count unchanged on that edge; in WAIT, clr_timer is ignored (hlt follows REQ-021).
REQ-024 clr_timer=1 in RUN: t_count=0, instr_count +1; if step_mode=1 next state is STEP_IDLE, else RUN.
REQ-025 No clr_timer at t_count=NUM_T-1: t_count wraps to 0, instr_count +1, overrun set to 1; step_mode handled as in REQ-024.
REQ-026 Otherwise in RUN: t_count +1.
REQ-027 STEP_IDLE -> RUN, t_count=0, on a step_req rising edge, or on any edge with step_mode=0.
REQ-028 HALT -> RUN, t_count=0, on a resume rising edge; hlt is ignored on that edge. HALT also exits to STEP_IDLE when step_mode=1.
REQ-029 Edge detection for resume and step_req uses a one-flop history reset to 0; an input held high at reset release does not trigger.
REQ-030 instr_count wraps modulo 2**CNT_WIDTH without flagging; overrun clears only on reset.
REQ-031 All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-032 reset=0: state=IDLE, t_count=0, T=0, instr_start=0, waiting=halted=stepping=0, instr_count=0, overrun=0, edge-history flops=0.
REQ-033 reset asserted mid-instruction or in WAIT/HALT aborts immediately; no partial retire is counted.

Verification
REQ-034 Reset release with T_WIDTH=3 and clr_timer asserted whenever t_count=1 -> T sequence 0x01,0x02,0x01,0x02…; instr_count increments every 2 cycles.
REQ-035 mem_ready=0 for 3 cycles while t_count=1 -> T=0x02 held for 4 cycles, waiting=1 for 3; then t_count=2.
REQ-036 No clr_timer for 8 cycles -> t_count 0..7 then 0; overrun=1 and stays 1; instr_count=1.
REQ-037 hlt at t_count=2 -> halted=1, T=0 next cycle; resume pulse -> T=0x01 one cycle later; resume held high with no new edge causes no further exit.
REQ-038 step_mode=1 with a 2-cycle instruction -> stepping=1 after retire; each step_req pulse runs exactly one instruction (instr_count +1).
REQ-039 reset=0 asynchronously mid-cycle during WAIT -> all outputs reach reset values before the next clk edge; resumes at T[0] after release.

Source files
------------

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// T-state sequencer for a simple microcoded CPU. It produces a one-hot T-state
// strobe that the control unit uses to step through each instruction. It also
// handles memory wait states, halt/resume, single-instruction stepping, and
// retired-instruction accounting.
//
// Parameters
//   T_WIDTH    width of the T-state counter (NUM_T = 2**T_WIDTH states)
//   CNT_WIDTH  width of the retired-instruction counter
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   mem_ready    memory/port ready; low inserts a wait state
//   clr_timer    end of instruction; the next T-state is T[0]
//   hlt          halt request
//   resume       leave HALT (rising-edge detected)
//   step_mode    1 = single-instruction stepping
//   step_req     run one instruction in step mode (rising-edge detected)
//   T            one-hot T-state strobe, zero outside RUN/WAIT
//   t_count      current T-state index
//   instr_start  first T-state of an instruction while running
//   waiting      sequencer is in WAIT
//   halted       sequencer is in HALT
//   stepping     sequencer is parked between instructions in step mode
//   instr_count  retired-instruction count (wraps silently)
//   overrun      sticky: the T-state counter wrapped without clr_timer
//
// Every output is either a flop or a decode of flops; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter  int T_WIDTH   = 3,
    parameter  int CNT_WIDTH = 16,
    localparam int NUM_T     = 2 ** T_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_ready,
    input  logic                 clr_timer,
    input  logic                 hlt,
    input  logic                 resume,
    input  logic                 step_mode,
    input  logic                 step_req,
    output logic [NUM_T-1:0]     T,
    output logic [T_WIDTH-1:0]   t_count,
    output logic                 instr_start,
    output logic                 waiting,
    output logic                 halted,
    output logic                 stepping,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_HALT,
        ST_STEP_IDLE
    } state_t;

    localparam logic [T_WIDTH-1:0] T_LAST = '1;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [T_WIDTH-1:0]   t_count_q, t_count_d;
    logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
    logic                 overrun_q, overrun_d;
    logic                 resume_q;
    logic                 step_req_q;

    // Combinational helpers
    logic                 retire;
    logic                 resume_rise;
    logic                 step_rise;

    // The history flops reset to 0. An input that is already high when reset
    // is released therefore shows a "rise" on the IDLE->RUN edge. IDLE
    // ignores both requests, so such a stale level never triggers anything.
    assign resume_rise = resume & ~resume_q;
    assign step_rise   = step_req & ~step_req_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here is given a default before the case.
    // Paths that do not mention a signal then hold it, and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        t_count_d = t_count_q;
        overrun_d = overrun_q;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d   = ST_RUN;
                t_count_d = '0;
            end

            ST_RUN: begin
                if (hlt) begin
                    // The HLT instruction itself retires.
                    state_d   = ST_HALT;
                    t_count_d = '0;
                    retire    = 1'b1;
                end else if (!mem_ready) begin
                    // Freeze the current T-state until memory answers.
                    state_d = ST_WAIT;
                end else if (clr_timer) begin
                    state_d   = step_mode ? ST_STEP_IDLE : ST_RUN;
                    t_count_d = '0;
                    retire    = 1'b1;
                end else if (t_count_q == T_LAST) begin
                    // The control unit never ended the instruction. Force a
                    // boundary and record the fault.
                    state_d   = step_mode ? ST_STEP_IDLE : ST_RUN;
                    t_count_d = '0;
                    retire    = 1'b1;
                    overrun_d = 1'b1;
                end else begin
                    t_count_d = t_count_q + T_WIDTH'(1);
                end
            end

            ST_WAIT: begin
                // clr_timer is deliberately ignored here. The T-state that was
                // stalled must be re-presented once memory is ready.
                if (hlt) begin
                    state_d   = ST_HALT;
                    t_count_d = '0;
                    retire    = 1'b1;
                end else if (mem_ready) begin
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                // hlt is not examined here, so resume wins even if hlt is
                // still asserted on the same edge.
                if (resume_rise) begin
                    state_d   = step_mode ? ST_STEP_IDLE : ST_RUN;
                    t_count_d = '0;
                end
            end

            ST_STEP_IDLE: begin
                if (step_rise || !step_mode) begin
                    state_d   = ST_RUN;
                    t_count_d = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                t_count_d = '0;
            end
        endcase

        instr_count_d = instr_count_q + CNT_WIDTH'(retire);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            t_count_q     <= '0;
            instr_count_q <= '0;
            overrun_q     <= 1'b0;
            resume_q      <= 1'b0;
            step_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            t_count_q     <= t_count_d;
            instr_count_q <= instr_count_d;
            overrun_q     <= overrun_d;
            resume_q      <= resume;
            step_req_q    <= step_req;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        T = '0;
        if (state_q == ST_RUN || state_q == ST_WAIT) begin
            T[t_count_q] = 1'b1;
        end
    end

    assign t_count     = t_count_q;
    assign instr_start = (state_q == ST_RUN) && (t_count_q == '0);
    assign waiting     = (state_q == ST_WAIT);
    assign halted      = (state_q == ST_HALT);
    assign stepping    = (state_q == ST_STEP_IDLE);
    assign instr_count = instr_count_q;
    assign overrun     = overrun_q;

    // The strobe can never have more than one T-state active.
    a_t_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(T));

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer (T_WIDTH=3, CNT_WIDTH=16). Inputs change
// 1 time unit after a rising edge. Outputs are checked at the same point,
// so each check sees the state that the preceding edge produced.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic        clr_timer;
    logic        hlt;
    logic        resume;
    logic        step_mode;
    logic        step_req;
    logic [7:0]  T;
    logic [2:0]  t_count;
    logic        instr_start;
    logic        waiting;
    logic        halted;
    logic        stepping;
    logic [15:0] instr_count;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    cpu_sequencer #(.T_WIDTH(3), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_ready   (mem_ready),
        .clr_timer   (clr_timer),
        .hlt         (hlt),
        .resume      (resume),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .T           (T),
        .t_count     (t_count),
        .instr_start (instr_start),
        .waiting     (waiting),
        .halted      (halted),
        .stepping    (stepping),
        .instr_count (instr_count),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected values of the common outputs after an edge.
    task automatic expect_run(input string tag, input logic [7:0] t_exp,
                              input logic [15:0] cnt_exp);
        check({tag, ".T"}, 32'(T), 32'(t_exp));
        check({tag, ".cnt"}, 32'(instr_count), 32'(cnt_exp));
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        clr_timer = 1'b0;
        hlt       = 1'b0;
        resume    = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;

        // ---------------- reset state ----------------
        #3;
        check("rst.T", 32'(T), 32'h0);
        check("rst.t_count", 32'(t_count), 32'h0);
        check("rst.flags", {26'b0, instr_start, waiting, halted, stepping, overrun, 1'b0}, 32'h0);
        check("rst.cnt", 32'(instr_count), 32'h0);
        tick();
        check("rst_held.T", 32'(T), 32'h0);
        #2 reset = 1'b1;

        // ---------------- first strobe is T[0] ----------------
        tick();
        expect_run("start", 8'h01, 16'd0);
        check("start.instr_start", 32'(instr_start), 32'h1);

        // ---------------- 2-cycle instructions: T = 01,02,01,02 ----------------
        for (int i = 0; i < 3; i++) begin
            clr_timer = 1'b0;
            tick();
            expect_run($sformatf("two_cyc%0d.t1", i), 8'h02, 16'(i));
            check($sformatf("two_cyc%0d.is0", i), 32'(instr_start), 32'h0);
            clr_timer = 1'b1;
            tick();
            expect_run($sformatf("two_cyc%0d.t0", i), 8'h01, 16'(i + 1));
        end

        // ---------------- wait states at t_count=1 ----------------
        clr_timer = 1'b0;
        tick();
        expect_run("pre_wait", 8'h02, 16'd3);
        // clr_timer is held high throughout. mem_ready=0 outranks it in RUN,
        // and WAIT ignores it.
        mem_ready = 1'b0;
        clr_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_run($sformatf("wait%0d", i), 8'h02, 16'd3);
            check($sformatf("wait%0d.waiting", i), 32'(waiting), 32'h1);
        end
        mem_ready = 1'b1;
        tick();
        expect_run("wait_exit", 8'h02, 16'd3);
        check("wait_exit.waiting", 32'(waiting), 32'h0);
        clr_timer = 1'b0;
        tick();
        check("post_wait.t_count", 32'(t_count), 32'd2);

        // ---------------- overrun: no clr_timer through t_count 7 ----------------
        for (int k = 3; k < 8; k++) begin
            tick();
            check($sformatf("ovr.t%0d", k), 32'(t_count), 32'(k));
            check($sformatf("ovr.flag%0d", k), 32'(overrun), 32'h0);
        end
        tick();
        expect_run("ovr_wrap", 8'h01, 16'd4);
        check("ovr_wrap.flag", 32'(overrun), 32'h1);
        tick();
        check("ovr_sticky.flag", 32'(overrun), 32'h1);
        check("ovr_sticky.t", 32'(t_count), 32'd1);

        // ---------------- halt / resume ----------------
        tick();
        check("pre_hlt.t", 32'(t_count), 32'd2);
        hlt = 1'b1;
        tick();
        expect_run("hlt", 8'h00, 16'd5);
        check("hlt.halted", 32'(halted), 32'h1);
        check("hlt.t", 32'(t_count), 32'd0);
        tick();
        check("hlt_hold.halted", 32'(halted), 32'h1);
        check("hlt_hold.cnt", 32'(instr_count), 32'd5);
        hlt    = 1'b0;
        resume = 1'b1;
        tick();
        expect_run("resume", 8'h01, 16'd5);
        check("resume.halted", 32'(halted), 32'h0);
        tick();
        check("resume_run.t", 32'(t_count), 32'd1);
        hlt = 1'b1;
        tick();
        check("hlt2.halted", 32'(halted), 32'h1);
        check("hlt2.cnt", 32'(instr_count), 32'd6);
        hlt = 1'b0;
        // resume is still high: no new edge, so HALT must hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("resume_level%0d", i), 32'(halted), 32'h1);
        end
        resume = 1'b0;
        tick();
        check("resume_low.halted", 32'(halted), 32'h1);
        // Fresh edge together with hlt: hlt is ignored on the exit edge.
        resume = 1'b1;
        hlt    = 1'b1;
        tick();
        expect_run("resume_hlt", 8'h01, 16'd6);
        check("resume_hlt.halted", 32'(halted), 32'h0);
        hlt    = 1'b0;
        resume = 1'b0;

        // hlt while in WAIT retires and halts.
        mem_ready = 1'b0;
        tick();
        check("wait_hlt.waiting", 32'(waiting), 32'h1);
        hlt = 1'b1;
        tick();
        expect_run("wait_hlt", 8'h00, 16'd7);
        check("wait_hlt.halted", 32'(halted), 32'h1);
        hlt       = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("wait_hlt_hold", 32'(halted), 32'h1);
        resume = 1'b1;
        tick();
        expect_run("wait_hlt_resume", 8'h01, 16'd7);
        resume = 1'b0;

        // ---------------- single stepping ----------------
        step_mode = 1'b1;
        tick();
        check("step.t1", 32'(t_count), 32'd1);
        clr_timer = 1'b1;
        tick();
        expect_run("step_park", 8'h00, 16'd8);
        check("step_park.stepping", 32'(stepping), 32'h1);
        check("step_park.is", 32'(instr_start), 32'h0);
        clr_timer = 1'b0;
        tick();
        check("step_idle_hold", 32'(stepping), 32'h1);
        step_req = 1'b1;
        tick();
        expect_run("step_go", 8'h01, 16'd8);
        check("step_go.is", 32'(instr_start), 32'h1);
        tick();
        check("step_go.t1", 32'(t_count), 32'd1);
        clr_timer = 1'b1;
        tick();
        expect_run("step_park2", 8'h00, 16'd9);
        check("step_park2.stepping", 32'(stepping), 32'h1);
        clr_timer = 1'b0;
        tick();
        check("step_level", 32'(stepping), 32'h1);
        step_req = 1'b0;
        tick();
        check("step_low", 32'(stepping), 32'h1);
        step_req = 1'b1;
        tick();
        expect_run("step_go2", 8'h01, 16'd9);
        step_req  = 1'b0;
        step_mode = 1'b0;
        tick();
        clr_timer = 1'b1;
        tick();
        expect_run("nostep_retire", 8'h01, 16'd10);
        check("nostep_retire.stepping", 32'(stepping), 32'h0);
        step_mode = 1'b1;
        tick();
        check("step_park3", 32'(stepping), 32'h1);
        check("step_park3.cnt", 32'(instr_count), 32'd11);
        // Dropping step_mode releases STEP_IDLE without a step_req edge.
        step_mode = 1'b0;
        clr_timer = 1'b0;
        tick();
        expect_run("step_mode_off", 8'h01, 16'd11);
        check("step_mode_off.stepping", 32'(stepping), 32'h0);

        // ---------------- asynchronous reset during WAIT ----------------
        tick();
        mem_ready = 1'b0;
        tick();
        check("pre_arst.waiting", 32'(waiting), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst.T", 32'(T), 32'h0);
        check("arst.waiting", 32'(waiting), 32'h0);
        check("arst.t_count", 32'(t_count), 32'h0);
        check("arst.cnt", 32'(instr_count), 32'h0);
        check("arst.overrun", 32'(overrun), 32'h0);
        mem_ready = 1'b1;
        #2 reset = 1'b1;
        tick();
        expect_run("arst_release", 8'h01, 16'd0);
        check("arst_release.is", 32'(instr_start), 32'h1);

        // ---------------- instr_count wraps silently ----------------
        // With clr_timer held at T[0], every RUN cycle retires one instruction.
        clr_timer = 1'b1;
        repeat (65535) tick();
        check("cnt_max", 32'(instr_count), 32'hffff);
        tick();
        check("cnt_wrap", 32'(instr_count), 32'h0);
        check("cnt_wrap.overrun", 32'(overrun), 32'h0);
        check("cnt_wrap.T", 32'(T), 32'h01);
        clr_timer = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
